debug_ctrl: RTL

DEBUG_CTRL -- requirements
Module: debug_ctrl

---
 rtl/debug_ctrl_if.sv | 26 ++
 rtl/debug_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/debug_ctrl_if.sv
// Debug host link: command channel into debug_ctrl and response channel back out.
// Both channels use valid/ready; a transfer happens on a cycle where both are high.
interface debug_ctrl_if #(
  parameter int XLEN = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [1:0]      cmd_tgt;
  logic [XLEN-1:0] cmd_addr;
  logic [XLEN-1:0] cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_tgt, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_tgt, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/debug_ctrl.sv
// Debug controller: halt/resume/step the core and access imem/dmem/regfile; response 1 cycle after accept
// (2 for write/step, RD_LAT+1 for read). One command in flight; response held until rsp_ready.
module debug_ctrl #(
  parameter int XLEN         = 32,
  parameter int RAW          = 5,
  parameter int RD_LAT       = 1,
  parameter bit RESET_HALTED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  debug_ctrl_if.slave     dbg,
  output logic            core_stall,
  output logic            halted,
  output logic            imem_oe,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_data,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dmem_oe,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_data,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            reg_oe,
  output logic            reg_we,
  output logic [RAW-1:0]  reg_ra,
  output logic [XLEN-1:0] reg_data,
  input  logic [XLEN-1:0] reg_rdata
);

  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_HALTED = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_RD     = 3'd4;
  localparam logic [2:0] S_RSP    = 3'd5;
  localparam logic [2:0] S_INIT   = RESET_HALTED ? S_HALTED : S_RUN;

  localparam logic [2:0] OP_HALT   = 3'd0;
  localparam logic [2:0] OP_RESUME = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_WRITE  = 3'd4;

  localparam logic [1:0] TGT_IMEM = 2'd0;
  localparam logic [1:0] TGT_DMEM = 2'd1;
  localparam logic [1:0] TGT_REG  = 2'd2;

  typedef struct packed {
    logic [1:0]      tgt;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } cmd_t;

  logic [2:0]      state;
  cmd_t            cmd_q;
  logic [2:0]      rd_cnt;
  logic [XLEN-1:0] rsp_dat_q;
  logic            rsp_err_q;
  logic            halt_after;
  logic            bad_access;
  logic            bus_act;
  logic [XLEN-1:0] sel_rdata;

  // Memory accesses are only legal while halted, to an existing target and register index.
  assign bad_access = (state == S_RUN) || (dbg.cmd_tgt == 2'd3) ||
                      ((dbg.cmd_tgt == TGT_REG) && (|dbg.cmd_addr[XLEN-1:RAW]));

  always_comb begin
    sel_rdata = '0;
    case (cmd_q.tgt)
      TGT_IMEM: sel_rdata = imem_rdata;
      TGT_DMEM: sel_rdata = dmem_rdata;
      TGT_REG:  sel_rdata = reg_rdata;
      default:  sel_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      cmd_q      <= '0;
      rd_cnt     <= '0;
      rsp_dat_q  <= '0;
      rsp_err_q  <= 1'b0;
      halt_after <= RESET_HALTED;
    end else begin
      case (state)
        S_RUN, S_HALTED: begin
          if (dbg.cmd_valid) begin
            cmd_q      <= '{tgt: dbg.cmd_tgt, addr: dbg.cmd_addr, data: dbg.cmd_data};
            rsp_dat_q  <= '0;
            rsp_err_q  <= 1'b0;
            halt_after <= (state == S_HALTED);
            state      <= S_RSP;
            case (dbg.cmd_op)
              OP_HALT:   halt_after <= 1'b1;
              OP_RESUME: halt_after <= 1'b0;
              OP_STEP: begin
                if (state == S_HALTED) state <= S_STEP;
                else rsp_err_q <= 1'b1;
              end
              OP_READ: begin
                if (bad_access) begin
                  rsp_err_q <= 1'b1;
                end else begin
                  state  <= S_RD;
                  rd_cnt <= 3'(RD_LAT - 1);
                end
              end
              OP_WRITE: begin
                if (bad_access) rsp_err_q <= 1'b1;
                else state <= S_WR;
              end
              default: rsp_err_q <= 1'b1;
            endcase
          end
        end
        S_STEP: state <= S_RSP;
        S_WR:   state <= S_RSP;
        S_RD: begin
          // Read data is captured on the final cycle of the oe window.
          if (rd_cnt == 3'd0) begin
            rsp_dat_q <= sel_rdata;
            state     <= S_RSP;
          end else begin
            rd_cnt <= rd_cnt - 3'd1;
          end
        end
        S_RSP: begin
          if (dbg.rsp_ready) state <= halt_after ? S_HALTED : S_RUN;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus_act        = (state == S_WR) || (state == S_RD);
  assign dbg.cmd_ready  = (state == S_RUN) || (state == S_HALTED);
  assign dbg.rsp_valid  = (state == S_RSP);
  assign dbg.rsp_data   = dbg.rsp_valid ? rsp_dat_q : '0;
  assign dbg.rsp_err    = dbg.rsp_valid ? rsp_err_q : 1'b0;

  assign core_stall = !((state == S_RUN) || (state == S_STEP));
  assign halted     = core_stall && (state != S_STEP);

  assign imem_oe   = (state == S_RD) && (cmd_q.tgt == TGT_IMEM);
  assign imem_we   = (state == S_WR) && (cmd_q.tgt == TGT_IMEM);
  assign imem_addr = (bus_act && (cmd_q.tgt == TGT_IMEM)) ? cmd_q.addr : '0;
  assign imem_data = imem_we ? cmd_q.data : '0;

  assign dmem_oe   = (state == S_RD) && (cmd_q.tgt == TGT_DMEM);
  assign dmem_we   = (state == S_WR) && (cmd_q.tgt == TGT_DMEM);
  assign dmem_addr = (bus_act && (cmd_q.tgt == TGT_DMEM)) ? cmd_q.addr : '0;
  assign dmem_data = dmem_we ? cmd_q.data : '0;

  assign reg_oe   = (state == S_RD) && (cmd_q.tgt == TGT_REG);
  assign reg_we   = (state == S_WR) && (cmd_q.tgt == TGT_REG);
  assign reg_ra   = (bus_act && (cmd_q.tgt == TGT_REG)) ? cmd_q.addr[RAW-1:0] : '0;
  assign reg_data = reg_we ? cmd_q.data : '0;

endmodule
